// File: rtl/vga_pkg.sv
// Shared VGA timing package: receiver lock states, default timing shared with
// the timing generator, and the 10-bit wrap-around increment used by both.
package vga_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

    localparam int unsigned DEF_HACTIVE     = 635;
    localparam int unsigned DEF_HFP         = 15;
    localparam int unsigned DEF_HSYN        = 95;
    localparam int unsigned DEF_HBP         = 48;
    localparam int unsigned DEF_VACTIVE     = 480;
    localparam int unsigned DEF_VFP         = 10;
    localparam int unsigned DEF_VSYN        = 2;
    localparam int unsigned DEF_VBP         = 33;
    localparam int unsigned DEF_LOCK_FRAMES = 2;

    function automatic logic [9:0] wrap_inc(input logic [9:0] value, input logic [9:0] limit);
        return (value == limit - 10'd1) ? 10'd0 : value + 10'd1;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one active-low sync input and reports its falling/rising edges
// combinationally against the registered level.
module vga_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic sync,
    output logic fall,
    output logic rise,
    output logic level
);

    logic sync_q;

    // NOTE: reset to the idle (high) level so a sync already asserted out of
    // reset is seen as a fresh falling edge rather than silently ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 1'b1;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            sync_q <= sync;
        end
    end

    assign fall  = sync_q & ~sync;
    assign rise  = ~sync_q & sync;
    assign level = sync_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// Sink-side VGA timing recovery: regenerates hpos/vpos/de from hsync/vsync and
// tracks lock. Optional period measurement is built when VGA_RX_MEASURE_EN is defined.
module vga_sync_receiver
    import vga_pkg::*;
#(
    parameter int unsigned HACTIVE     = DEF_HACTIVE,
    parameter int unsigned HFP         = DEF_HFP,
    parameter int unsigned HSYN        = DEF_HSYN,
    parameter int unsigned HBP         = DEF_HBP,
    parameter int unsigned VACTIVE     = DEF_VACTIVE,
    parameter int unsigned VFP         = DEF_VFP,
    parameter int unsigned VSYN        = DEF_VSYN,
    parameter int unsigned VBP         = DEF_VBP,
    parameter int unsigned LOCK_FRAMES = DEF_LOCK_FRAMES
) (
    input  logic       vgaclk,
    input  logic       reset_n,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       de,
    output logic       locked,
    output logic       sync_err,
    output logic [9:0] hperiod_meas,
    output logic [9:0] vlines_meas
);

    localparam logic [9:0]  HMAX     = 10'(HACTIVE + HFP + HSYN + HBP);
    localparam logic [9:0]  VMAX     = 10'(VACTIVE + VFP + VSYN + VBP);
    localparam logic [9:0]  HACT     = 10'(HACTIVE);
    localparam logic [9:0]  VACT     = 10'(VACTIVE);
    localparam logic [9:0]  H_FALL   = 10'(HACTIVE + HFP);
    localparam logic [9:0]  H_RISE   = 10'(HACTIVE + HFP + HSYN);
    localparam logic [9:0]  V_FALL   = 10'(VACTIVE + VFP);
    localparam logic [10:0] TIMEOUT  = 11'(2 * (HACTIVE + HFP + HSYN + HBP));
    localparam logic [3:0]  LOCK_CNT = 4'(LOCK_FRAMES);

    logic hs_fall, hs_rise, unused_hs_level;
    logic vs_fall, vs_rise_unused, unused_vs_level;

    vga_sync_edge u_hs_edge (
        .clk     (vgaclk),
        .reset_n (reset_n),
        .sync    (hsync_in),
        .fall    (hs_fall),
        .rise    (hs_rise),
        .level   (unused_hs_level)
    );

    vga_sync_edge u_vs_edge (
        .clk     (vgaclk),
        .reset_n (reset_n),
        .sync    (vsync_in),
        .fall    (vs_fall),
        .rise    (vs_rise_unused),
        .level   (unused_vs_level)
    );

    rx_state_t   state_q, state_d;
    logic [9:0]  hpos_q, hpos_d, vpos_q, vpos_d;
    logic [9:0]  hpos_run, vpos_run;
    logic [10:0] to_q, to_d;
    logic [3:0]  good_q, good_d;
    logic        vseen_q, vseen_d;
    logic        sync_err_q, sync_err_d;
    logic        bad_hfall, bad_hrise, bad_vfall, timeout, violation;

    // Free-run next values; every edge check compares against these.
    always_comb begin
        hpos_run = wrap_inc(hpos_q, HMAX);
        vpos_run = (hpos_q == HMAX - 10'd1) ? wrap_inc(vpos_q, VMAX) : vpos_q;
    end

    // The first vsync fall after entering VERIFY only aligns vpos, so it is not checked.
    assign bad_hfall = hs_fall && (hpos_run != H_FALL);
    assign bad_hrise = hs_rise && (hpos_run != H_RISE);
    assign bad_vfall = vs_fall && vseen_q && ((vpos_run != V_FALL) || (hpos_run != 10'd0));
    assign timeout   = !hs_fall && (to_q == TIMEOUT - 11'd1);
    assign violation = bad_hfall || bad_hrise || bad_vfall || timeout;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d    = state_q;
        good_d     = good_q;
        vseen_d    = vseen_q;
        sync_err_d = 1'b0;
        hpos_d     = hs_fall ? H_FALL : hpos_run;
        vpos_d     = vpos_run;
        to_d       = hs_fall ? 11'd0 : ((to_q == TIMEOUT) ? to_q : to_q + 11'd1);

        case (state_q)
            SEARCH: begin
                if (hs_fall) begin
                    state_d = VERIFY;
                    vpos_d  = 10'd0;
                    good_d  = 4'd0;
                    vseen_d = 1'b0;
                end
            end
            VERIFY: begin
                if (violation) begin
                    state_d = SEARCH;
                end else if (vs_fall) begin
                    if (!vseen_q) begin
                        vseen_d = 1'b1;
                    end else begin
                        good_d = good_q + 4'd1;
                        if (good_q + 4'd1 == LOCK_CNT) begin
                            state_d = LOCKED;
                        end
                    end
                end
            end
            LOCKED: begin
                if (violation) begin
                    state_d    = SEARCH;
                    sync_err_d = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase

        if (vs_fall) begin
            vpos_d = V_FALL;
        end
    end

    always_ff @(posedge vgaclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SEARCH;
            hpos_q     <= 10'd0;
            vpos_q     <= 10'd0;
            to_q       <= 11'd0;
            good_q     <= 4'd0;
            vseen_q    <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hpos_q     <= hpos_d;
            vpos_q     <= vpos_d;
            to_q       <= to_d;
            good_q     <= good_d;
            vseen_q    <= vseen_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign hpos     = hpos_q;
    assign vpos     = vpos_q;
    assign locked   = (state_q == LOCKED);
    assign de       = locked && (hpos_q < HACT) && (vpos_q < VACT);
    assign sync_err = sync_err_q;

`ifdef VGA_RX_MEASURE_EN
    logic [9:0] hcyc_q, hcyc_d, hper_q, hper_d;
    logic [9:0] vln_q, vln_d, vlin_q, vlin_d;

    // A line fall coinciding with the frame fall still belongs to the ending frame.
    always_comb begin
        hcyc_d = (hcyc_q == 10'h3FF) ? hcyc_q : hcyc_q + 10'd1;
        hper_d = hper_q;
        vln_d  = vln_q;
        vlin_d = vlin_q;
        if (hs_fall) begin
            hper_d = hcyc_q;
            hcyc_d = 10'd1;
            if (vln_q != 10'h3FF) begin
                vln_d = vln_q + 10'd1;
            end
        end
        if (vs_fall) begin
            vlin_d = vln_d;
            vln_d  = 10'd0;
        end
    end

    always_ff @(posedge vgaclk or negedge reset_n) begin
        if (!reset_n) begin
            hcyc_q <= 10'd0;
            hper_q <= 10'd0;
            vln_q  <= 10'd0;
            vlin_q <= 10'd0;
        end else begin
            hcyc_q <= hcyc_d;
            hper_q <= hper_d;
            vln_q  <= vln_d;
            vlin_q <= vlin_d;
        end
    end

    assign hperiod_meas = hper_q;
    assign vlines_meas  = vlin_q;
`else
    assign hperiod_meas = 10'd0;
    assign vlines_meas  = 10'd0;
`endif

endmodule

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Sink-side VGA timing recovery. Samples the active-low `hsync`/`vsync` pair produced by the VGA timing generator (or an external source on the same `vgaclk`), regenerates pixel coordinates and a data-enable, and declares lock after consecutive well-formed frames. Sits at the input of the capture/loopback path, feeding frame-buffer write logic and the self-test checker.

## Interface
- `HACTIVE`, 635, visible pixels per line
- `HFP`, 15, horizontal front porch
- `HSYN`, 95, hsync pulse width
- `HBP`, 48, horizontal back porch
- `VACTIVE`, 480, visible lines
- `VFP`, 10, vertical front porch
- `VSYN`, 2, vsync pulse width
- `VBP`, 33, vertical back porch
- `LOCK_FRAMES`, 2, consecutive good frames required for lock (1..15)
- `vgaclk`  in  1  pixel clock; the only clock
- `reset_n`  in  1  asynchronous, active-low reset
- `hsync_in`  in  1  active-low hsync, synchronous to `vgaclk`
- `vsync_in`  in  1  active-low vsync, synchronous to `vgaclk`
- `hpos`  out  10  recovered horizontal count
- `vpos`  out  10  recovered vertical count
- `de`  out  1  high inside the visible area while locked
- `locked`  out  1  timing lock status
- `sync_err`  out  1  one-cycle pulse on any violation while LOCKED
- `hperiod_meas`  out  10  measured cycles between hsync falling edges
- `vlines_meas`  out  10  measured lines between vsync falling edges

## Operation
- HMAX = HACTIVE+HFP+HSYN+HBP (793); VMAX = VACTIVE+VFP+VSYN+VBP (525). All position arithmetic is 10-bit unsigned.
- `hsync_in`/`vsync_in` are registered once (`hs_q`, `vs_q`; reset value 1). A falling edge means `hs_q`=1 and `hsync_in`=0; a rising edge is the reverse.
- Free-run: `hpos` increments each cycle, wrapping HMAX-1 -> 0. On that wrap, `vpos` increments, wrapping VMAX-1 -> 0.
- hsync falling edge: `hpos` loads HACTIVE+HFP, overriding the increment.
- vsync falling edge: `vpos` loads VACTIVE+VFP, overriding any increment in the same cycle. Simultaneous h and v loads both apply.
- Checks compare each edge with the free-run next value:
  - hsync fall: expected `hpos` = HACTIVE+HFP.
  - hsync rise: expected `hpos` = HACTIVE+HFP+HSYN.
  - vsync fall: expected `vpos` = VACTIVE+VFP and expected `hpos` = 0.
  - Timeout: an 11-bit counter, cleared on each hsync fall, reaching 2*HMAX is a violation.
- State machine (reset state SEARCH):
  - SEARCH -> VERIFY on the first hsync fall. `vpos` is cleared and the good-frame count is cleared.
  - VERIFY: the first vsync fall loads `vpos` unchecked. Each later checked-good vsync fall increments the good-frame count. Reaching LOCK_FRAMES -> LOCKED. Any violation -> SEARCH, with no `sync_err` pulse.
  - LOCKED: any violation pulses `sync_err` for one cycle and goes to SEARCH; `locked` drops in the same cycle.
- `locked` = (state == LOCKED). `de` = `locked` & (`hpos` < HACTIVE) & (`vpos` < VACTIVE).
- The edge-triggered loads take effect in every state, including the edge that causes a violation.

## Timing
- Reset values: `hpos`=0, `vpos`=0, `de`=0, `locked`=0, `sync_err`=0, `hperiod_meas`=0, `vlines_meas`=0.
- Reset acts immediately, including mid-frame.
- Latency: while LOCKED, `hpos`/`vpos`/`de` equal the generator's `hcnt`/`vcnt`/`blank_b` delayed by exactly one `vgaclk`.
- Lock acquisition, clean input, LOCK_FRAMES=2: `locked` rises on the cycle of the third vsync falling edge after reset.
- `sync_err` is registered and asserts on the cycle after the offending edge is sampled.

## Configuration
- `VGA_RX_MEASURE_EN` defined:
  - `hperiod_meas` updates on each hsync fall to the cycle count since the previous fall (saturates at 1023).
  - `vlines_meas` updates on each vsync fall to the hsync-fall count since the previous vsync fall.
  - Both update in every state.
- Macro undefined: both ports are driven constant 0 and the measurement counters are not built.

## Structure
- Shared package `vga_pkg`:
  - `rx_state_t` enum {SEARCH, VERIFY, LOCKED}
  - default timing localparams, shared with the timing generator
- One sub-module, `vga_sync_edge`:
  - inputs: clk, reset_n, active-low sync
  - outputs: `fall`, `rise`, registered level
  - instantiated once each for hsync and vsync.

## Test plan
- Reset: hold `reset_n`=0 with toggling syncs -> all outputs 0, `locked`=0.
- Clean default stream from a generator model -> `locked` at the third vsync fall; thereafter `hpos`/`vpos` track generator counts +1 cycle; `de` high 635×480 cycles per frame; `sync_err` never pulses.
- Short line while LOCKED: hsync fall when free-run `hpos` would be 700 -> `sync_err` one-cycle pulse, `locked`=0, `hpos` loads 650, state SEARCH.
- Sync loss: hold `hsync_in`=1 while LOCKED -> `sync_err` pulse and `locked`=0 exactly 1586 cycles after the last hsync fall.
- Async reset mid-frame at `hpos`=300, `vpos`=200 -> outputs 0 immediately; relock after three vsync falls.
- Measurement:
  - With `VGA_RX_MEASURE_EN`: after one full frame `hperiod_meas`=793 and `vlines_meas`=525.
  - Without the macro: both read 0 throughout.
